// File: rtl/bs_job_sequencer.sv
// bs_job_sequencer: host register file, job FSM and result FIFO in front of the Black-Scholes core (ports: host slave address/write/writedata/read/readdata, core shadow constants, core_req, core_status, core_dout, irq)
module bs_job_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY = 28
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [31:0] core_constK,
  output logic [31:0] core_const1,
  output logic [31:0] core_const2,
  output logic [31:0] core_const3,
  output logic        core_req,
  input  logic [4:0]  core_status,
  input  logic [31:0] core_dout,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] stage [4];
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic [7:0] cnt;
  logic overflow, swb, busy, start, clear, capture, pop, push, full, drop;
  logic [31:0] stat, rdata_n;
  logic unused_status;
  assign unused_status = ^core_status[4:1];
  always_comb begin
    busy = state != IDLE;
    core_req = state == ISSUE;
    start = write && address == 3'd4 && writedata[0];
    clear = write && address == 3'd4 && writedata[1];
    capture = state == WAIT && (core_status[0] || cnt == 8'(LATENCY - 1));
    pop = read && address == 3'd6 && count != '0;
    full = count == CW'(FIFO_DEPTH);
    push = capture && (!full || pop);
    drop = capture && full && !pop;
    count_n = count + CW'(push) - CW'(pop);
    stat = '0;
    stat[0] = busy;
    stat[4 +: CW] = count;
    stat[12] = overflow;
    stat[13] = swb;
    rdata_n = address < 3'd4 ? stage[address[1:0]] : address == 3'd5 ? stat : pop ? mem[rd_ptr] : '0;
    state_n = state == IDLE ? (start ? ISSUE : IDLE) : state == ISSUE ? WAIT : capture ? IDLE : WAIT;
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) stage[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      core_constK <= '0;
      core_const1 <= '0;
      core_const2 <= '0;
      core_const3 <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      swb <= 1'b0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      if (write && !address[2]) stage[address[1:0]] <= writedata;
      if (state == IDLE && start) begin
        core_constK <= stage[0];
        core_const1 <= stage[1];
        core_const2 <= stage[2];
        core_const3 <= stage[3];
      end
      cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (push) begin
        mem[wr_ptr] <= core_dout;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      irq <= count_n != '0;
      // clear is applied before the new events so a combined clear+event re-sets the flag
      overflow <= (overflow && !clear) || drop;
      swb <= (swb && !clear) || (start && busy);
      if (read) readdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_bs_job_sequencer.sv
// tb_bs_job_sequencer: directed scoreboard bench for bs_job_sequencer
module tb_bs_job_sequencer;
  localparam int LAT = 28;
  logic clk = 1'b0, nreset = 1'b0;
  logic [2:0] address = '0;
  logic write = 1'b0, read = 1'b0;
  logic [31:0] writedata = '0, readdata;
  logic [31:0] core_constK, core_const1, core_const2, core_const3;
  logic core_req, irq;
  logic [4:0] core_status = '0;
  logic [31:0] core_dout = '0;
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  logic [31:0] exp_q [$];
  logic [31:0] d;
  bs_job_sequencer #(.FIFO_DEPTH(4), .LATENCY(LAT)) dut (
    .clk(clk), .nreset(nreset), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .core_constK(core_constK), .core_const1(core_const1),
    .core_const2(core_const2), .core_const3(core_const3), .core_req(core_req),
    .core_status(core_status), .core_dout(core_dout), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    address = a;
    writedata = v;
    write = 1'b1;
    tick;
    write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    read = 1'b1;
    tick;
    read = 1'b0;
    v = readdata;
  endtask
  function automatic logic [31:0] stat_v(input logic b, input int c, input logic o, input logic s);
    return {18'b0, s, o, 3'b0, 5'(c), 3'b0, b};
  endfunction
  task automatic pop_chk(input string tag);
    logic [31:0] v, e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    rd(3'd6, v);
    chk(tag, v, e);
  endtask
  task automatic run_job(input logic [31:0] v, input bit early, input bit exp_push);
    wr(3'd4, 32'd1);
    core_dout = v;
    if (early) begin
      tick;
      core_status = 5'd1;
      tick;
      core_status = 5'd0;
    end else repeat (LAT + 1) tick;
    if (exp_push) exp_q.push_back(v);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_readdata", readdata, 0);
    chk("rst_req", 32'(core_req), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_constK", core_constK, 0);
    nreset = 1'b1;
    tick;
    wr(3'd0, 32'h42C80000);
    wr(3'd1, 32'h3F800000);
    wr(3'd2, 32'h40000000);
    wr(3'd3, 32'h40400000);
    wr(3'd4, 32'd1);
    core_dout = 32'hA5A50001;
    chk("t1_req_hi", 32'(core_req), 1);
    chk("t1_constK", core_constK, 32'h42C80000);
    chk("t1_const1", core_const1, 32'h3F800000);
    chk("t1_const2", core_const2, 32'h40000000);
    chk("t1_const3", core_const3, 32'h40400000);
    tick;
    chk("t1_req_lo", 32'(core_req), 0);
    repeat (LAT - 1) tick;
    chk("t1_irq_before", 32'(irq), 0);
    tick;
    chk("t1_irq_after", 32'(irq), 1);
    core_dout = 32'hFFFFFFFF;
    exp_q.push_back(32'hA5A50001);
    rd(3'd5, d);
    chk("t1_stat", d, stat_v(0, 1, 0, 0));
    pop_chk("t1_result");
    chk("t1_irq_pop", 32'(irq), 0);
    wr(3'd4, 32'd1);
    tick;
    tick;
    tick;
    core_status = 5'd1;
    core_dout = 32'h12345678;
    chk("t2_irq_pre", 32'(irq), 0);
    tick;
    core_status = 5'd0;
    chk("t2_irq", 32'(irq), 1);
    exp_q.push_back(32'h12345678);
    rd(3'd5, d);
    chk("t2_stat", d, stat_v(0, 1, 0, 0));
    pop_chk("t2_result");
    chk("t2_irq_pop", 32'(irq), 0);
    rd(3'd5, d);
    chk("t2_stat_empty", d, 0);
    wr(3'd4, 32'd1);
    core_dout = 32'h33;
    tick;
    tick;
    tick;
    wr(3'd0, 32'hDEADBEEF);
    wr(3'd4, 32'd3);
    chk("t3_constK_frozen", core_constK, 32'h42C80000);
    rd(3'd5, d);
    chk("t3_stat_busy", d, stat_v(1, 0, 0, 1));
    repeat (LAT - 5) tick;
    exp_q.push_back(32'h33);
    rd(3'd5, d);
    chk("t3_stat_done", d, stat_v(0, 1, 0, 1));
    pop_chk("t3_result");
    wr(3'd4, 32'd2);
    rd(3'd5, d);
    chk("t3_clear", d, 0);
    run_job(32'h44, 1, 1);
    chk("t3_constK_new", core_constK, 32'hDEADBEEF);
    pop_chk("t3_result2");
    for (int i = 1; i <= 5; i++) run_job(32'(i), 1, i <= 4);
    rd(3'd5, d);
    chk("t4_stat_ovf", d, stat_v(0, 4, 1, 0));
    chk("t4_irq", 32'(irq), 1);
    wr(3'd4, 32'd2);
    rd(3'd5, d);
    chk("t4_stat_clr", d, stat_v(0, 4, 0, 0));
    wr(3'd4, 32'd1);
    tick;
    core_status = 5'd1;
    core_dout = 32'd5;
    address = 3'd6;
    read = 1'b1;
    tick;
    read = 1'b0;
    core_status = 5'd0;
    chk("t4_pop_full", readdata, exp_q.pop_front());
    exp_q.push_back(32'd5);
    rd(3'd5, d);
    chk("t4_stat_coinc", d, stat_v(0, 4, 0, 0));
    for (int i = 0; i < 4; i++) pop_chk("t4_drain");
    rd(3'd5, d);
    chk("t4_stat_empty", d, 0);
    chk("t4_irq_empty", 32'(irq), 0);
    wr(3'd0, 32'h11111111);
    rd(3'd0, d);
    chk("t5_stage_rd", d, 32'h11111111);
    wr(3'd4, 32'd1);
    core_dout = 32'h77;
    tick;
    tick;
    nreset = 1'b0;
    #1;
    chk("t5_req", 32'(core_req), 0);
    chk("t5_irq", 32'(irq), 0);
    chk("t5_readdata", readdata, 0);
    chk("t5_constK", core_constK, 0);
    chk("t5_const1", core_const1, 0);
    @(negedge clk);
    nreset = 1'b1;
    tick;
    repeat (LAT + 2) tick;
    chk("t5_irq_late", 32'(irq), 0);
    rd(3'd5, d);
    chk("t5_stat", d, 0);
    rd(3'd0, d);
    chk("t5_stage_zero", d, 0);
    rd(3'd6, d);
    chk("t5_result_empty", d, 0);
    run_job(32'h99, 0, 1);
    chk("t5_constK_after", core_constK, 0);
    rd(3'd5, d);
    chk("t5_stat_job", d, stat_v(0, 1, 0, 0));
    pop_chk("t5_result");
    rd(3'd6, d);
    chk("t6_empty_rd", d, 0);
    rd(3'd7, d);
    chk("t6_addr7", d, 0);
    rd(3'd4, d);
    chk("t6_ctrl_rd", d, 0);
    wr(3'd7, 32'hFFFFFFFF);
    rd(3'd5, d);
    chk("t6_stat", d, 0);
    run_job(32'hAB, 1, 1);
    pop_chk("t6_ptr_intact");
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/bs_job_sequencer.md
# bs_job_sequencer

Host-side job sequencer that sits directly upstream of the Black-Scholes processor core. It exposes the core's four 32-bit constants (K, C1, C2, C3) as host-writable registers and freezes them into shadow registers when a job starts. It issues a one-cycle request to the core, waits for completion, and captures the core's 32-bit result into a small FIFO for the host to read. All host traffic uses a simple memory-mapped slave port with one-cycle read latency.

## Interface
- FIFO_DEPTH, 4: result FIFO entries; power of two, 2..16.
- LATENCY, 28: maximum core cycles from request to valid result; range 1..255.
- clk  in  1  clock; all logic on the rising edge.
- nreset  in  1  asynchronous, active-low reset.
- address  in  3  register index.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- read  in  1  read strobe, single cycle.
- readdata  out  32  read data, registered; valid the cycle after `read`.
- core_constK, core_const1, core_const2, core_const3  out  32 each  shadow constants to the core.
- core_req  out  1  job request pulse to the core.
- core_status  in  5  core status; bit 0 = result done.
- core_dout  in  32  core result.
- irq  out  1  high while the FIFO is non-empty.

## Operation
- Register map (word index):
  - 0 K, 1 C1, 2 C2, 3 C3: read/write staging registers.
  - 4 CTRL: write-only. Bit 0 = start, bit 1 = clear sticky flags. Reads return 0.
  - 5 STAT: read-only. Bit 0 busy, bits 8:4 FIFO count, bit 12 overflow (sticky), bit 13 start_while_busy (sticky).
  - 6 RESULT: read pops the FIFO head; an empty read returns 0 and does not pop.
  - 7: reserved; reads return 0, writes are ignored.
- FSM states:
  - IDLE: a start write moves to ISSUE and copies the staging registers into the shadow registers on the same edge.
  - ISSUE: `core_req` = 1 for exactly this one cycle; clears the wait counter; always moves to WAIT.
  - WAIT: the 8-bit counter increments each cycle. Capture happens when `core_status[0]` = 1 or counter = LATENCY-1, whichever is first. On capture, `core_dout` is pushed to the FIFO and the FSM returns to IDLE.
- Busy = state ≠ IDLE.
- Start while busy: the start is ignored, `start_while_busy` is set, and the running job is unaffected.
- Staging writes while busy update the staging registers only; the shadow registers stay frozen until the next start.
- Capture with the FIFO full and no same-cycle pop: the result is dropped, `overflow` is set, and the FIFO is unchanged.
- Capture and RESULT pop in the same cycle, FIFO full: the pop happens first, then the push; count stays at FIFO_DEPTH and no overflow is flagged.
- Capture and pop in the same cycle, FIFO empty: the pop sees empty and returns 0; the push then lands, so count = 1.
- CTRL write with bits 0 and 1 both set: the flags are cleared first, then start is evaluated. A start while busy then re-sets `start_while_busy`.
- FIFO pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH and needs log2(FIFO_DEPTH)+1 bits.
- Reset, asynchronous: FSM to IDLE, all registers/shadows/pointers/flags 0, `readdata` 0, `core_req` 0, `irq` 0.
  - A reset mid-job abandons the job; no result is captured.

## Timing
- Start write in cycle T: `core_req` = 1 in cycle T+1; WAIT begins at T+2 with counter 0.
- Without done, capture happens at the end of cycle T+1+LATENCY. STAT shows the incremented count and busy = 0 from cycle T+2+LATENCY.
- Done seen in WAIT cycle W: capture at the end of W; earliest capture is the end of T+2.
- Back-to-back jobs: the next start is accepted in the first IDLE cycle, so the minimum job period is LATENCY+2 cycles.
- Read latency is 1 cycle. `readdata` holds its value until the next read.
- `irq` is registered from the FIFO count and follows it with zero extra delay, i.e. it updates on the same edge as the count.

## Test plan
- Write K=0x42C80000, C1=0x3F800000, C2=0x40000000, C3=0x40400000, then start -> shadows equal the writes at T+1, `core_req` pulses at T+1 only, capture at T+1+28, RESULT read returns the `core_dout` value held at capture.
- Drive `core_status[0]`=1 at the third WAIT cycle with `core_dout`=0x12345678 -> capture at that cycle, FIFO count 1, `irq`=1; RESULT read -> 0x12345678, count 0, `irq`=0.
- Start during WAIT, and write K=0xDEADBEEF during WAIT -> the job completes normally, `start_while_busy`=1, `core_constK` unchanged until the next start; CTRL write 0x2 clears the flag.
- Run 5 jobs with FIFO_DEPTH=4 and no reads -> count 4, `overflow`=1, the FIFO holds results 1-4 in order; a full pop coincident with the 5th capture instead gives count 4 and `overflow`=0.
- Assert nreset mid-WAIT -> all outputs 0, FIFO empty, FSM IDLE. Then a RESULT read -> `readdata`=0; a new start operates normally.
- Read RESULT on an empty FIFO and read address 7 -> both return 0 with no pointer change.
